pipeline_ctrl: RTL

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 22 ++
 rtl/pipeline_ctrl.sv | 93 +++++++++
 2 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and helpers for the pipeline stall/flush controller.
// No logic or latency of its own. No backpressure.
package pipeline_ctrl_pkg;

    localparam int          STALL_W            = 6;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

    // Highest requesting stage wins, so the result is always a contiguous run of ones from bit 0.
    function automatic logic [STALL_W-1:0] stall_prefix(
        input logic s_if,
        input logic s_id,
        input logic s_ex,
        input logic s_mem
    );
        if (s_mem)     return 6'b011111;
        else if (s_ex) return 6'b001111;
        else if (s_id) return 6'b000111;
        else if (s_if) return 6'b000011;
        else           return 6'b000000;
    endfunction

endpackage

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/redirect controller: per-stage stall prefix, exception flush, then PC redirect.
// Latency: stall and accept-cycle flush are combinational; exc_pc is registered on accept.
// Backpressure: a MEM stall holds off exception accept; stall_from_if holds the redirect.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_from_if,
    input  logic               stall_from_id,
    input  logic               stall_from_ex,
    input  logic               stall_from_mem,
    input  logic               exc_valid,
    input  logic               exc_is_eret,
    input  logic [31:0]        cp0_epc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic               pc_redirect,
    output logic [31:0]        exc_pc
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [3:0]           r_cnt;
    logic [31:0]          r_exc_pc;
    logic                 w_exc_accept;
    logic [STALL_W-1:0]   w_stall;
    logic                 w_flush;
    logic                 w_redirect;

    // rst gates the accept so nothing reaches the outputs while reset is held.
    assign w_exc_accept = rst && (r_state == S_IDLE) && exc_valid && !stall_from_mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_exc_pc <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_exc_accept) begin
                r_cnt    <= 4'(FLUSH_CYCLES - 1);
                r_exc_pc <= exc_is_eret ? cp0_epc : EXC_VECTOR;
            end else if (r_state == S_FLUSH) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_stall    = '0;
        w_flush    = 1'b0;
        w_redirect = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_exc_accept) begin
                    w_flush = 1'b1;
                    w_next  = (FLUSH_CYCLES > 1) ? S_FLUSH : S_REDIRECT;
                end else if (rst) begin
                    w_stall = stall_prefix(stall_from_if, stall_from_id,
                                           stall_from_ex, stall_from_mem);
                end
            end
            S_FLUSH: begin
                w_flush = 1'b1;
                if (r_cnt <= 4'd1) w_next = S_REDIRECT;
            end
            S_REDIRECT: begin
                // Hold PC and IF until fetch can take the new target.
                w_redirect = 1'b1;
                w_stall    = {4'b0000, stall_from_if, stall_from_if};
                if (!stall_from_if) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign stall       = w_stall;
    assign flush       = w_flush;
    assign pc_redirect = w_redirect;
    assign exc_pc      = r_exc_pc;

endmodule
